// File: rtl/fanctrl_cfg_pkg.sv
// Shared constants for the fan-controller nibble config loader: address map, FSM states, nibble counts.
// Latency: n/a (definitions only); backpressure: n/a.
package fanctrl_cfg_pkg;

  localparam int DEF_ADC_BITWIDTH = 8;
  localparam int DEF_REG_BITWIDTH = 32;
  localparam int CNT_W            = 8;

  localparam logic [3:0] ADDR_ADC    = 4'h0;
  localparam logic [3:0] ADDR_SET    = 4'h1;
  localparam logic [3:0] ADDR_PERIOD = 4'h2;
  localparam logic [3:0] ADDR_MIN    = 4'h3;
  localparam logic [3:0] ADDR_A0     = 4'h4;
  localparam logic [3:0] ADDR_A1     = 4'h5;
  localparam logic [3:0] ADDR_B0     = 4'h6;
  localparam logic [3:0] ADDR_B1     = 4'h7;
  localparam logic [3:0] ADDR_B2     = 4'h8;
  localparam logic [3:0] ADDR_COMMIT = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_DATA
  } state_t;

  // Data nibbles needed to carry a value of the given bit width.
  function automatic int nib_count(input int width);
    return (width + 3) / 4;
  endfunction

  localparam int NIB_VAL_DEF = nib_count(DEF_ADC_BITWIDTH);
  localparam int NIB_PER_DEF = nib_count(DEF_ADC_BITWIDTH + 1);
  localparam int NIB_REG_DEF = DEF_REG_BITWIDTH / 4;

endpackage

// File: rtl/fanctrl_cfg_loader_if.sv
// Nibble input bus plus the parallel data/config outputs of the loader.
// Latency: n/a (wiring only); backpressure: none, nibble source is free-running.
interface fanctrl_cfg_loader_if
  import fanctrl_cfg_pkg::*;
#(
  parameter int ADC_BITWIDTH = DEF_ADC_BITWIDTH,
  parameter int REG_BITWIDTH = DEF_REG_BITWIDTH
);
  logic [3:0]                     nibble_i;
  logic                           nibble_strb_i;
  logic [ADC_BITWIDTH-1:0]        ADC_value_o;
  logic [ADC_BITWIDTH-1:0]        SET_value_o;
  logic [ADC_BITWIDTH:0]          PWM_periodCounterValue_o;
  logic [ADC_BITWIDTH-1:0]        PWM_minCounterValue_o;
  logic                           config_en_o;
  logic                           dataVaild_STRB_o;
  logic signed [REG_BITWIDTH-1:0] a0_o;
  logic signed [REG_BITWIDTH-1:0] a1_o;
  logic signed [REG_BITWIDTH-1:0] b0_o;
  logic signed [REG_BITWIDTH-1:0] b1_o;
  logic signed [REG_BITWIDTH-1:0] b2_o;
  logic                           busy_o;
  logic                           err_o;

  modport master (
    input  nibble_i, nibble_strb_i,
    output ADC_value_o, SET_value_o, PWM_periodCounterValue_o, PWM_minCounterValue_o,
           config_en_o, dataVaild_STRB_o, a0_o, a1_o, b0_o, b1_o, b2_o, busy_o, err_o
  );

  modport slave (
    output nibble_i, nibble_strb_i,
    input  ADC_value_o, SET_value_o, PWM_periodCounterValue_o, PWM_minCounterValue_o,
           config_en_o, dataVaild_STRB_o, a0_o, a1_o, b0_o, b1_o, b2_o, busy_o, err_o
  );
endinterface

// File: rtl/cfg_strb_sync.sv
// Two-flop synchronizer for the async nibble/strobe pair with rising-edge detect on the strobe.
// Latency: nib_valid 2 clk after the strobe rises; backpressure: none.
module cfg_strb_sync (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] nibble_i,
  input  logic       nibble_strb_i,
  output logic       nib_valid,
  output logic [3:0] nib_data
);

  logic [3:0] nib_s1_q, nib_s1_d, nib_s2_q, nib_s2_d;
  logic       strb_s1_q, strb_s1_d, strb_s2_q, strb_s2_d, strb_s3_q, strb_s3_d;

  always_comb begin
    nib_s1_d  = nibble_i;
    nib_s2_d  = nib_s1_q;
    strb_s1_d = nibble_strb_i;
    strb_s2_d = strb_s1_q;
    strb_s3_d = strb_s2_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      nib_s1_q  <= '0;
      nib_s2_q  <= '0;
      strb_s1_q <= 1'b0;
      strb_s2_q <= 1'b0;
      strb_s3_q <= 1'b0;
    end else begin
      nib_s1_q  <= nib_s1_d;
      nib_s2_q  <= nib_s2_d;
      strb_s1_q <= strb_s1_d;
      strb_s2_q <= strb_s2_d;
      strb_s3_q <= strb_s3_d;
    end
  end

  // The nibble was settled well before the strobe, so its synchronized copy is valid here.
  assign nib_valid = strb_s2_q & ~strb_s3_q;
  assign nib_data  = nib_s2_q;

endmodule

// File: rtl/fanctrl_cfg_loader.sv
// Nibble-bus frame decoder feeding fan-controller data, PWM config and shadowed PID coefficients.
// Latency: target updates 1 clk after the last nibble is seen; backpressure: none, timeout aborts stalled frames.
module fanctrl_cfg_loader
  import fanctrl_cfg_pkg::*;
#(
  parameter int ADC_BITWIDTH   = DEF_ADC_BITWIDTH,
  parameter int REG_BITWIDTH   = DEF_REG_BITWIDTH,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PERIOD_RST     = 255
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  fanctrl_cfg_loader_if.master bus
);

  localparam int NIB_VAL = nib_count(ADC_BITWIDTH);
  localparam int NIB_PER = nib_count(ADC_BITWIDTH + 1);
  localparam int NIB_REG = REG_BITWIDTH / 4;
  localparam int PER_W   = ADC_BITWIDTH + 1;
  localparam int SH_W    = (REG_BITWIDTH > 4 * NIB_PER) ? REG_BITWIDTH : 4 * NIB_PER;
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic       nib_valid;
  logic [3:0] nib_data;

  cfg_strb_sync u_sync (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .nibble_i     (bus.nibble_i),
    .nibble_strb_i(bus.nibble_strb_i),
    .nib_valid    (nib_valid),
    .nib_data     (nib_data)
  );

  state_t                         state_q, state_d;
  logic [3:0]                     addr_q, addr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [TMO_W-1:0]               tmo_q, tmo_d;
  logic [SH_W-5:0]                shift_q, shift_d;
  logic [SH_W-1:0]                word;
  logic [ADC_BITWIDTH-1:0]        adc_q, adc_d, set_q, set_d, min_q, min_d;
  logic [PER_W-1:0]               per_q, per_d;
  logic                           cfg_en_q, cfg_en_d, dv_q, dv_d, err_q, err_d;
  logic signed [REG_BITWIDTH-1:0] shd_q [5];
  logic signed [REG_BITWIDTH-1:0] shd_d [5];
  logic signed [REG_BITWIDTH-1:0] coef_q [5];
  logic signed [REG_BITWIDTH-1:0] coef_d [5];

  // Value accumulated so far with the incoming nibble appended as the LSBs.
  assign word = {shift_q, nib_data};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    shift_d  = shift_q;
    adc_d    = adc_q;
    set_d    = set_q;
    min_d    = min_q;
    per_d    = per_q;
    cfg_en_d = cfg_en_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    shd_d    = shd_q;
    coef_d   = coef_q;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (nib_valid) begin
          addr_d  = nib_data;
          shift_d = '0;
          case (nib_data)
            ADDR_ADC, ADDR_SET, ADDR_MIN: begin
              cnt_d   = CNT_W'(NIB_VAL);
              state_d = ST_DATA;
            end
            ADDR_PERIOD: begin
              cnt_d   = CNT_W'(NIB_PER);
              state_d = ST_DATA;
            end
            ADDR_A0, ADDR_A1, ADDR_B0, ADDR_B1, ADDR_B2: begin
              cnt_d   = CNT_W'(NIB_REG);
              state_d = ST_DATA;
            end
            ADDR_COMMIT: coef_d = shd_q;
            default:     err_d  = 1'b1;
          endcase
        end
      end
      ST_DATA: begin
        // A strobe landing on the expiry cycle still counts; the timeout only fires on a quiet cycle.
        if (nib_valid) begin
          tmo_d   = '0;
          shift_d = word[SH_W-5:0];
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            case (addr_q)
              ADDR_ADC: begin
                adc_d    = word[ADC_BITWIDTH-1:0];
                cfg_en_d = 1'b0;
                dv_d     = 1'b1;
              end
              ADDR_SET: begin
                set_d    = word[ADC_BITWIDTH-1:0];
                cfg_en_d = 1'b1;
                dv_d     = 1'b1;
              end
              ADDR_PERIOD: per_d    = word[PER_W-1:0];
              ADDR_MIN:    min_d    = word[ADC_BITWIDTH-1:0];
              ADDR_A0:     shd_d[0] = $signed(word[REG_BITWIDTH-1:0]);
              ADDR_A1:     shd_d[1] = $signed(word[REG_BITWIDTH-1:0]);
              ADDR_B0:     shd_d[2] = $signed(word[REG_BITWIDTH-1:0]);
              ADDR_B1:     shd_d[3] = $signed(word[REG_BITWIDTH-1:0]);
              ADDR_B2:     shd_d[4] = $signed(word[REG_BITWIDTH-1:0]);
              default:     ;
            endcase
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      shift_q  <= '0;
      adc_q    <= '0;
      set_q    <= '0;
      min_q    <= '0;
      per_q    <= PER_W'(PERIOD_RST);
      cfg_en_q <= 1'b0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      shd_q    <= '{default: '0};
      coef_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      shift_q  <= shift_d;
      adc_q    <= adc_d;
      set_q    <= set_d;
      min_q    <= min_d;
      per_q    <= per_d;
      cfg_en_q <= cfg_en_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      shd_q    <= shd_d;
      coef_q   <= coef_d;
    end
  end

  assign bus.ADC_value_o              = adc_q;
  assign bus.SET_value_o              = set_q;
  assign bus.PWM_periodCounterValue_o = per_q;
  assign bus.PWM_minCounterValue_o    = min_q;
  assign bus.config_en_o              = cfg_en_q;
  assign bus.dataVaild_STRB_o         = dv_q;
  assign bus.err_o                    = err_q;
  assign bus.busy_o                   = (state_q == ST_DATA);
  assign bus.a0_o                     = coef_q[0];
  assign bus.a1_o                     = coef_q[1];
  assign bus.b0_o                     = coef_q[2];
  assign bus.b1_o                     = coef_q[3];
  assign bus.b2_o                     = coef_q[4];

endmodule

// File: tb/tb_fanctrl_cfg_loader.sv
// Self-checking bench for fanctrl_cfg_loader: directed frames then random frames against a frame-level model.
// Short timeout parameter keeps stall scenarios brief.
module tb_fanctrl_cfg_loader;

  localparam int ADCW = 8;
  localparam int REGW = 32;
  localparam int TMO  = 64;
  localparam int PRST = 255;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fanctrl_cfg_loader_if #(.ADC_BITWIDTH(ADCW), .REG_BITWIDTH(REGW)) bus ();

  fanctrl_cfg_loader #(
    .ADC_BITWIDTH  (ADCW),
    .REG_BITWIDTH  (REGW),
    .TIMEOUT_CYCLES(TMO),
    .PERIOD_RST    (PRST)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int dv_seen  = 0;
  int err_seen = 0;

  // Reference model: register contents and expected pulse totals.
  logic [ADCW-1:0] m_adc, m_set, m_min;
  logic [ADCW:0]   m_per;
  logic            m_cfg;
  logic [REGW-1:0] m_shd [5];
  logic [REGW-1:0] m_coef [5];
  int              m_dv  = 0;
  int              m_err = 0;

  always @(negedge clk) begin
    if (bus.dataVaild_STRB_o) dv_seen++;
    if (bus.err_o) err_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nibs(input logic [3:0] a);
    if (a == 4'h0 || a == 4'h1 || a == 4'h3) return (ADCW + 3) / 4;
    if (a == 4'h2) return (ADCW + 4) / 4;
    if (a >= 4'h4 && a <= 4'h8) return REGW / 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_adc = '0; m_set = '0; m_min = '0; m_cfg = 1'b0;
    m_per = (ADCW+1)'(PRST);
    for (int i = 0; i < 5; i++) begin
      m_shd[i]  = '0;
      m_coef[i] = '0;
    end
  endtask

  task automatic model_frame(input logic [3:0] a, input logic [63:0] d);
    if (a == 4'h0) begin m_adc = d[ADCW-1:0]; m_cfg = 1'b0; m_dv++; end
    else if (a == 4'h1) begin m_set = d[ADCW-1:0]; m_cfg = 1'b1; m_dv++; end
    else if (a == 4'h2) m_per = d[ADCW:0];
    else if (a == 4'h3) m_min = d[ADCW-1:0];
    else if (a >= 4'h4 && a <= 4'h8) m_shd[int'(a) - 4] = d[REGW-1:0];
    else if (a == 4'hF) for (int i = 0; i < 5; i++) m_coef[i] = m_shd[i];
    else m_err++;
  endtask

  task automatic send_nib(input logic [3:0] n);
    @(posedge clk);
    bus.nibble_i = n;
    repeat (4) @(posedge clk);
    bus.nibble_strb_i = 1'b1;
    repeat (4) @(posedge clk);
    bus.nibble_strb_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [3:0] a, input int n, input logic [63:0] d);
    send_nib(a);
    for (int i = n - 1; i >= 0; i--) send_nib(d[4*i +: 4]);
    repeat (4) @(posedge clk);
    model_frame(a, d);
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    chk($sformatf("%s.adc", tag), 64'(bus.ADC_value_o), 64'(m_adc));
    chk($sformatf("%s.set", tag), 64'(bus.SET_value_o), 64'(m_set));
    chk($sformatf("%s.per", tag), 64'(bus.PWM_periodCounterValue_o), 64'(m_per));
    chk($sformatf("%s.min", tag), 64'(bus.PWM_minCounterValue_o), 64'(m_min));
    chk($sformatf("%s.cfg", tag), 64'(bus.config_en_o), 64'(m_cfg));
    chk($sformatf("%s.a0", tag), 64'($unsigned(bus.a0_o)), 64'(m_coef[0]));
    chk($sformatf("%s.a1", tag), 64'($unsigned(bus.a1_o)), 64'(m_coef[1]));
    chk($sformatf("%s.b0", tag), 64'($unsigned(bus.b0_o)), 64'(m_coef[2]));
    chk($sformatf("%s.b1", tag), 64'($unsigned(bus.b1_o)), 64'(m_coef[3]));
    chk($sformatf("%s.b2", tag), 64'($unsigned(bus.b2_o)), 64'(m_coef[4]));
    chk($sformatf("%s.busy", tag), 64'(bus.busy_o), 64'(0));
    chk($sformatf("%s.dvcnt", tag), 64'(dv_seen), 64'(m_dv));
    chk($sformatf("%s.errcnt", tag), 64'(err_seen), 64'(m_err));
  endtask

  initial begin
    logic [3:0]  a;
    logic [63:0] d;
    int          n, k;

    bus.nibble_i      = 4'h0;
    bus.nibble_strb_i = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    check_all("rst");

    send_frame(4'h1, 2, 64'hA5);
    check_all("set");

    send_frame(4'h4, 8, 64'h12345678);
    check_all("shadow");
    send_frame(4'hF, 0, 64'h0);
    check_all("commit");

    send_frame(4'h2, 3, 64'h1FF);
    check_all("period");

    // Stalled ADC frame: aborts with an error and leaves registers alone.
    send_nib(4'h0);
    send_nib(4'h3);
    @(negedge clk);
    chk("tmo.busy_mid", 64'(bus.busy_o), 64'(1));
    repeat (TMO + 20) @(posedge clk);
    m_err++;
    check_all("timeout");
    send_frame(4'h0, 2, 64'h42);
    check_all("adc");

    // Slow but in-time frame must still complete.
    send_nib(4'h3);
    send_nib(4'h7);
    repeat (TMO - 24) @(posedge clk);
    send_nib(4'h9);
    repeat (4) @(posedge clk);
    model_frame(4'h3, 64'h79);
    check_all("slow");

    send_frame(4'h9, 0, 64'h0);
    check_all("badaddr");

    // Asynchronous reset in the middle of a coefficient frame.
    send_nib(4'h5);
    send_nib(4'h1);
    send_nib(4'h2);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst.a0", 64'($unsigned(bus.a0_o)), 64'(0));
    chk("arst.per", 64'(bus.PWM_periodCounterValue_o), 64'(PRST));
    chk("arst.set", 64'(bus.SET_value_o), 64'(0));
    chk("arst.busy", 64'(bus.busy_o), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    check_all("rstmid");

    for (int r = 0; r < 30; r++) begin
      a = 4'($urandom_range(0, 15));
      d = {$urandom, $urandom};
      n = nibs(a);
      if (n > 0 && $urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, n - 1);
        send_nib(a);
        for (int i = 0; i < k; i++) send_nib(d[4*i +: 4]);
        repeat (TMO + 20) @(posedge clk);
        m_err++;
      end else begin
        send_frame(a, n, d);
      end
      check_all($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fanctrl_cfg_loader.md
Name: fanctrl_cfg_loader

Overview:
Upstream front-end for the fan controller. It turns a 4-bit nibble bus with a strobe (pin-limited tile) into the controller's parallel data and config inputs. These are ADC/SET values with a data-valid strobe, PWM period/min, and the five PID coefficients. Coefficients are staged in shadow registers and applied atomically, so the PID core never sees a half-updated set.

Parameters:
ADC_BITWIDTH, 8, width of ADC/SET/PWM-min values; PWM period is ADC_BITWIDTH+1
REG_BITWIDTH, 32, PID coefficient width
TIMEOUT_CYCLES, 100000, idle clocks mid-frame before abort (10 ms at 10 MHz)
PERIOD_RST, 255, reset value of PWM period output

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
nibble_i  in  4  data/address nibble, asynchronous to clk_i
nibble_strb_i  in  1  nibble strobe, asynchronous; rising edge = nibble valid
ADC_value_o  out  ADC_BITWIDTH  last received ADC value
SET_value_o  out  ADC_BITWIDTH  last received setpoint
PWM_periodCounterValue_o  out  ADC_BITWIDTH+1  PWM period
PWM_minCounterValue_o  out  ADC_BITWIDTH  PWM minimum count
config_en_o  out  1  1 after SET frame, 0 after ADC frame (level)
dataVaild_STRB_o  out  1  one-cycle pulse when ADC or SET frame completes
a0_o, a1_o, b0_o, b1_o, b2_o  out  REG_BITWIDTH each, signed  committed coefficients
busy_o  out  1  frame in progress
err_o  out  1  one-cycle pulse on bad address or timeout

Behaviour:
- Reset (async assert, synchronous release): all outputs 0 except PWM_periodCounterValue_o = PERIOD_RST. Shadows 0, FSM IDLE.
- Input sync: nibble_i and nibble_strb_i pass through 2-flop synchronizers. A rising edge is detected on the synchronized strobe and the synchronized nibble is captured on that edge. Nibble must be stable at least 3 clk before the strobe rises and held until it falls.
- Frame format: an address nibble, then N data nibbles, MSB first. The value is shifted in, and the low target-width bits are kept.
- Address map and N:
  - 0: ADC, N=ceil(ADC_BITWIDTH/4)
  - 1: SET, same N
  - 2: PWM period, N=ceil((ADC_BITWIDTH+1)/4)
  - 3: PWM min, N=ceil(ADC_BITWIDTH/4)
  - 4..8: shadow a0, a1, b0, b1, b2, N=REG_BITWIDTH/4
  - F: COMMIT, N=0
  - all others: invalid
- FSM:
  - IDLE: on strobe, decode the address.
    - Invalid address: err_o pulse, stay in IDLE.
    - F: copy all five shadows to the coefficient outputs in the next cycle, stay in IDLE.
    - Otherwise: load remaining count = N and go to DATA.
  - DATA: each strobe shifts in a nibble and decrements the count. When the count reaches 0, the target register updates in the next cycle and the FSM returns to IDLE.
  - busy_o = (state==DATA).
- ADC/SET completion: in the same cycle as the register update, config_en_o is set (1 for SET, 0 for ADC) and dataVaild_STRB_o pulses high for exactly one clk. The PWM/coefficient frames do not pulse it.
- Timeout:
  - The counter clears on every accepted strobe and counts only in DATA.
  - At TIMEOUT_CYCLES-1 the frame is discarded, err_o pulses, and the FSM goes to IDLE. No register changes.
  - If a strobe and timeout expiry fall in the same cycle, the strobe wins.
- Shadow writes never affect the outputs until COMMIT. A COMMIT with no prior shadow writes re-applies the current shadows.
- Reset mid-frame: the partial frame is lost and all registers return to their reset values.

Decomposition:
- Shared package fanctrl_cfg_pkg holds:
  - address constants (ADDR_ADC..ADDR_B2, ADDR_COMMIT)
  - FSM state encoding
  - nibble-count constants derived from the widths
- One natural sub-module, cfg_strb_sync: the 2-flop synchronizer for the nibble and strobe plus rising-edge detect. It outputs nib_valid and nib_data.

Test Plan:
- Reset released, no traffic -> period=255, all other outputs 0, busy_o=0, no pulses.
- Frame 1,A,5 -> SET_value_o=0xA5, config_en_o=1, one dataVaild_STRB_o pulse; ADC_value_o unchanged.
- Frame 4,1,2,3,4,5,6,7,8 -> a0_o still 0. Then frame F -> a0_o=0x12345678 and the other coefficients 0, all updating in the same cycle.
- Frame 2,1,F,F -> period=0x1FF; dataVaild_STRB_o stays 0.
- Frame 0,3 then stall TIMEOUT_CYCLES clocks -> err_o pulse, busy_o=0, ADC_value_o unchanged. Next frame 0,4,2 -> ADC=0x42, config_en_o=0, strobe pulse.
- Address nibble 9 -> err_o pulse, FSM stays IDLE. Also: rstn_i asserted mid-coefficient frame -> outputs return to reset values immediately (async).
